mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Fourth stage of the five-stage MIPS pipeline. Sits between EXE and WB and consumes the 154-bit EXE->MEM bus.
//  - Drives the synchronous data RAM for LW/LB/LBU/SW/SB.
//  - Aligns and sign-extends load data and holds it in a register across WB stalls.
//  - Forwards HI/LO/CP0/syscall information unchanged on the 118-bit MEM->WB bus.
// PARAMETERS
//  DM_LATENCY  1  cycles from dm_addr valid to dm_rdata valid (1..3)
// PORTS
//  clk          in   1    single clock, all flops on posedge
//  rst          in   1    asynchronous, active-high reset
//  MEM_valid    in   1    bus register holds a live instruction
//  MEM_adv      in   1    instruction leaves MEM at the next edge (MEM_over & WB_allow_in)
//  EXE_MEM_bus_r in  154  {mem_control[153:150],store_data[149:118],exe_result[117:86],lo_result[85:54],
//                          hi_write,lo_write,mfhi,mflo,mtc0,mfc0,cp0r_addr[47:40],syscall,eret,rf_wen,rf_wdest[36:32],pc[31:0]}
//  dm_addr      out  32   data RAM address = exe_result
//  dm_wen       out  4    byte write enables
//  dm_wdata     out  32   store data, byte-replicated for SB
//  dm_rdata     in   32   data RAM read data
//  MEM_over     out  1    stage result is valid on MEM_WB_bus
//  MEM_WB_bus   out  118  {rf_wen,rf_wdest,mem_result[32],lo_result[32],hi_write,lo_write,mfhi,mflo,mtc0,mfc0,cp0r_addr,syscall,eret,pc}
//  MEM_wdest    out  5    rf_wdest & {5{MEM_valid}}, used for hazard detection
//  MEM_addr_exc out  1    misaligned word access flag (see CONFIGURATION)
//  MEM_pc       out  32   pc of the instruction in MEM
// BEHAVIOUR
//  - mem_control = {inst_load, inst_store, ls_word, lb_sign}.
//  - Reset: state=IDLE, cnt=0, load_data_r=0.
//    Combinational outputs follow their inputs: dm_wen=0 whenever MEM_valid=0; MEM_over=0 unless MEM_valid.
//  - Non-load: MEM_over = MEM_valid in the same cycle (latency 0). mem_result = exe_result.
//  - Store: dm_wen valid whenever MEM_valid & inst_store, in any FSM state.
//    - SW: dm_wen=4'b1111, dm_wdata=store_data.
//    - SB: dm_wen=4'b0001<<addr[1:0], dm_wdata={4{store_data[7:0]}}.
//    - A re-write during a stall is idempotent and permitted.
//  - Load FSM (3 states):
//    - IDLE: on MEM_valid&inst_load go to WAIT with cnt=1. Cycle 0 presents the address.
//    - WAIT: cnt++ each cycle. When cnt==DM_LATENCY, capture aligned dm_rdata into load_data_r and go to DONE.
//    - DONE: MEM_over=1, mem_result=load_data_r. Stay until MEM_adv, then go to IDLE.
//    - Load latency = DM_LATENCY+1 cycles after MEM_valid rises (2 for the default).
//  - From any state, MEM_valid=0 (flush) -> IDLE at the next edge. MEM_adv in IDLE/WAIT has no effect.
//  - Back-to-back loads: MEM_adv in DONE -> IDLE. The next load starts in the following cycle.
//  - Alignment:
//    - LW uses the full word.
//    - LB/LBU select byte addr[1:0] (00 = bits[7:0], little-endian).
//    - lb_sign=1 sign-extends bit 7; lb_sign=0 zero-extends.
//  - rst asserted mid-load discards the load. MEM_over stays 0 until a new load completes.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//   - A word access with addr[1:0]!=0 sets MEM_addr_exc=MEM_valid.
//   - A store has dm_wen forced to 0.
//   - A load has rf_wen forced to 0 on MEM_WB_bus. The FSM timing is unchanged.
//  Not defined: MEM_addr_exc tied 0, addr[1:0] ignored for word accesses.
// STRUCTURE
//  - Shared package holds:
//    - bus widths EXE_MEM_W=154 and MEM_WB_W=118;
//    - mem_control bit indices LD/ST/WORD/SIGN;
//    - FSM state encodings IDLE/WAIT/DONE.
//  - One sub-module, load_align: combinational byte select and extension ({rdata,addr[1:0],ls_word,lb_sign} -> 32b).
// TESTING
//  - ALU pass-through: exe_result=0x12345678, rf_wdest=5, MEM_valid=1 -> same cycle MEM_over=1, mem_result=0x12345678, MEM_wdest=5.
//  - SB: addr=0x103, store_data=0xAB -> dm_wen=4'b1000, dm_wdata=0xABABABAB. SW to 0x100 -> dm_wen=4'b1111.
//  - LB with rdata=0x80FF7F01 at addr 0x...3 -> mem_result=0xFFFFFF80. LBU -> 0x00000080. LW -> 0x80FF7F01. Each MEM_over on cycle 2.
//  - DM_LATENCY=3, load then WB stall for 4 cycles with dm_rdata changed after capture -> MEM_over on cycle 4, mem_result stays at the captured value until MEM_adv.
//  - Flush/reset: MEM_valid drops in WAIT, then a new load -> completes normally. rst pulse in WAIT -> state IDLE, MEM_over=0.
//  - MEM_ALIGN_CHECK_EN: SW to 0x102 -> dm_wen=0, MEM_addr_exc=1. LW to 0x101 -> bus rf_wen=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, mem_control
// bit positions, load FSM encodings and the packed bus payload layouts.
`timescale 1ns/1ps
package mem_stage_pkg;

    localparam int unsigned EXE_MEM_W = 154;
    localparam int unsigned MEM_WB_W  = 118;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WEN_W     = 4;
    localparam int unsigned DEST_W    = 5;
    localparam int unsigned CNT_W     = 2;   // holds DM_LATENCY up to 3
    localparam int unsigned STATE_W   = 2;

    // mem_control = {inst_load, inst_store, ls_word, lb_sign}
    localparam int unsigned LD   = 3;
    localparam int unsigned ST   = 2;
    localparam int unsigned WORD = 1;
    localparam int unsigned SIGN = 0;

    // Load FSM encodings
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] WAIT = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

    typedef struct packed {
        logic [3:0]        mem_control;
        logic [DATA_W-1:0] store_data;
        logic [DATA_W-1:0] exe_result;
        logic [DATA_W-1:0] lo_result;
        logic              hi_write;
        logic              lo_write;
        logic              mfhi;
        logic              mflo;
        logic              mtc0;
        logic              mfc0;
        logic [7:0]        cp0r_addr;
        logic              syscall;
        logic              eret;
        logic              rf_wen;
        logic [DEST_W-1:0] rf_wdest;
        logic [DATA_W-1:0] pc;
    } exe_mem_bus_t;

    typedef struct packed {
        logic              rf_wen;
        logic [DEST_W-1:0] rf_wdest;
        logic [DATA_W-1:0] mem_result;
        logic [DATA_W-1:0] lo_result;
        logic              hi_write;
        logic              lo_write;
        logic              mfhi;
        logic              mflo;
        logic              mtc0;
        logic              mfc0;
        logic [7:0]        cp0r_addr;
        logic              syscall;
        logic              eret;
        logic [DATA_W-1:0] pc;
    } mem_wb_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// MEM stage bus bundle: EXE->MEM bus and handshake, data RAM port, MEM->WB
// bus and hazard/exception taps.
//   master : pipeline/RAM side driving MEM_valid, MEM_adv, EXE_MEM_bus_r, dm_rdata
//   slave  : the mem_stage itself
`timescale 1ns/1ps
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                 MEM_valid;
    logic                 MEM_adv;
    logic [EXE_MEM_W-1:0] EXE_MEM_bus_r;
    logic [DATA_W-1:0]    dm_addr;
    logic [WEN_W-1:0]     dm_wen;
    logic [DATA_W-1:0]    dm_wdata;
    logic [DATA_W-1:0]    dm_rdata;
    logic                 MEM_over;
    logic [MEM_WB_W-1:0]  MEM_WB_bus;
    logic [DEST_W-1:0]    MEM_wdest;
    logic                 MEM_addr_exc;
    logic [DATA_W-1:0]    MEM_pc;

    modport master (
        output MEM_valid, MEM_adv, EXE_MEM_bus_r, dm_rdata,
        input  dm_addr, dm_wen, dm_wdata, MEM_over, MEM_WB_bus,
               MEM_wdest, MEM_addr_exc, MEM_pc
    );

    modport slave (
        input  MEM_valid, MEM_adv, EXE_MEM_bus_r, dm_rdata,
        output dm_addr, dm_wen, dm_wdata, MEM_over, MEM_WB_bus,
               MEM_wdest, MEM_addr_exc, MEM_pc
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte (little-endian) for LB/LBU
// and sign- or zero-extends it; LW passes the full word through.
//   rdata   : raw data RAM word
//   addr_lo : byte offset addr[1:0]
//   ls_word : word access
//   lb_sign : sign-extend the byte
//   data_c  : aligned 32-bit result (combinational)
`timescale 1ns/1ps
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic              ls_word,
    input  logic              lb_sign,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0] byte_sel;

    // Byte lane select
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    // Word pass-through or byte extension
    always_comb begin
        data_c = rdata;
        if (!ls_word) begin
            data_c = {{24{lb_sign & byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline. Drives the synchronous data
// RAM, waits DM_LATENCY cycles for load data, aligns and holds it until WB
// accepts the instruction, and forwards the remaining EXE fields to WB.
//   clk, rst       : clock, asynchronous active-high reset
//   mem (slave)    : MEM_valid/MEM_adv handshake, EXE_MEM_bus_r in,
//                    dm_addr/dm_wen/dm_wdata/dm_rdata RAM port,
//                    MEM_over/MEM_WB_bus out, MEM_wdest, MEM_addr_exc, MEM_pc
// Parameter DM_LATENCY (1..3): address-to-read-data latency of the RAM.
// Optional macro MEM_ALIGN_CHECK_EN: flag misaligned word accesses, suppress
// their stores and their register write-back.
`timescale 1ns/1ps
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DM_LATENCY = 1
)(
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  mem
);

    exe_mem_bus_t       in_bus;
    mem_wb_bus_t        wb_bus;
    logic               inst_load;
    logic               inst_store;
    logic               ls_word;
    logic               lb_sign;
    logic [1:0]         addr_lo;
    logic               word_misalign;
    logic [WEN_W-1:0]   wen_c;
    logic [DATA_W-1:0]  aligned_c;
    logic [DATA_W-1:0]  load_data_q;
    logic [DATA_W-1:0]  mem_result_c;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               capture_c;
    logic               load_done_c;

    assign in_bus     = mem.EXE_MEM_bus_r;
    assign inst_load  = in_bus.mem_control[LD];
    assign inst_store = in_bus.mem_control[ST];
    assign ls_word    = in_bus.mem_control[WORD];
    assign lb_sign    = in_bus.mem_control[SIGN];
    assign addr_lo    = in_bus.exe_result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign word_misalign = ls_word & (inst_load | inst_store) & (addr_lo != 2'b00);
`else
    assign word_misalign = 1'b0;
`endif

    // Store byte enables; a repeated write while stalled is harmless
    always_comb begin
        wen_c = '0;
        if (mem.MEM_valid && inst_store && !word_misalign) begin
            wen_c = ls_word ? 4'b1111 : (4'b0001 << addr_lo);
        end
    end

    assign mem.dm_addr  = in_bus.exe_result;
    assign mem.dm_wen   = wen_c;
    assign mem.dm_wdata = ls_word ? in_bus.store_data : {4{in_bus.store_data[7:0]}};

    mem_stage_load_align u_align (
        .rdata   (mem.dm_rdata),
        .addr_lo (addr_lo),
        .ls_word (ls_word),
        .lb_sign (lb_sign),
        .data_c  (aligned_c)
    );

    // Load FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load FSM next state; cnt counts cycles since the address was presented
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_c   = 1'b0;
        load_done_c = 1'b0;
        if (!mem.MEM_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_load) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(DM_LATENCY)) begin
                        capture_c = 1'b1;
                        state_d   = DONE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    load_done_c = 1'b1;
                    if (mem.MEM_adv) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Captured load data survives WB stalls and later RAM activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data_q <= '0;
        end else if (capture_c) begin
            load_data_q <= aligned_c;
        end
    end

    assign mem_result_c = inst_load ? load_data_q : in_bus.exe_result;
    assign mem.MEM_over = mem.MEM_valid & (inst_load ? load_done_c : 1'b1);

    // MEM->WB payload
    always_comb begin
        wb_bus            = '0;
        wb_bus.rf_wen     = in_bus.rf_wen & ~(inst_load & word_misalign);
        wb_bus.rf_wdest   = in_bus.rf_wdest;
        wb_bus.mem_result = mem_result_c;
        wb_bus.lo_result  = in_bus.lo_result;
        wb_bus.hi_write   = in_bus.hi_write;
        wb_bus.lo_write   = in_bus.lo_write;
        wb_bus.mfhi       = in_bus.mfhi;
        wb_bus.mflo       = in_bus.mflo;
        wb_bus.mtc0       = in_bus.mtc0;
        wb_bus.mfc0       = in_bus.mfc0;
        wb_bus.cp0r_addr  = in_bus.cp0r_addr;
        wb_bus.syscall    = in_bus.syscall;
        wb_bus.eret       = in_bus.eret;
        wb_bus.pc         = in_bus.pc;
    end

    assign mem.MEM_WB_bus   = wb_bus;
    assign mem.MEM_wdest    = in_bus.rf_wdest & {DEST_W{mem.MEM_valid}};
    assign mem.MEM_addr_exc = mem.MEM_valid & word_misalign;
    assign mem.MEM_pc       = in_bus.pc;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int N  = 2;
    localparam int LA = 1;
    localparam int LB = 3;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [3:0] C_ALU = 4'b0000;
    localparam logic [3:0] C_LW  = 4'b1010;
    localparam logic [3:0] C_LB  = 4'b1001;
    localparam logic [3:0] C_LBU = 4'b1000;
    localparam logic [3:0] C_SW  = 4'b0110;
    localparam logic [3:0] C_SB  = 4'b0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         valid_r [N];
    logic         adv_r   [N];
    logic [153:0] bus_r   [N];
    logic [31:0]  rdata_r [N];

    logic         over_o  [N];
    logic [3:0]   wen_o   [N];
    logic [31:0]  addr_o  [N];
    logic [31:0]  wdata_o [N];
    logic [117:0] wb_o    [N];
    logic [4:0]   wdest_o [N];
    logic         exc_o   [N];
    logic [31:0]  pc_o    [N];

    mem_stage_if if0();
    mem_stage_if if1();

    assign if0.MEM_valid     = valid_r[0];
    assign if0.MEM_adv       = adv_r[0];
    assign if0.EXE_MEM_bus_r = bus_r[0];
    assign if0.dm_rdata      = rdata_r[0];
    assign if1.MEM_valid     = valid_r[1];
    assign if1.MEM_adv       = adv_r[1];
    assign if1.EXE_MEM_bus_r = bus_r[1];
    assign if1.dm_rdata      = rdata_r[1];

    assign over_o[0]  = if0.MEM_over;      assign over_o[1]  = if1.MEM_over;
    assign wen_o[0]   = if0.dm_wen;        assign wen_o[1]   = if1.dm_wen;
    assign addr_o[0]  = if0.dm_addr;       assign addr_o[1]  = if1.dm_addr;
    assign wdata_o[0] = if0.dm_wdata;      assign wdata_o[1] = if1.dm_wdata;
    assign wb_o[0]    = if0.MEM_WB_bus;    assign wb_o[1]    = if1.MEM_WB_bus;
    assign wdest_o[0] = if0.MEM_wdest;     assign wdest_o[1] = if1.MEM_wdest;
    assign exc_o[0]   = if0.MEM_addr_exc;  assign exc_o[1]   = if1.MEM_addr_exc;
    assign pc_o[0]    = if0.MEM_pc;        assign pc_o[1]    = if1.MEM_pc;

    mem_stage #(.DM_LATENCY(LA)) dut_a (.clk(clk), .rst(rst), .mem(if0.slave));
    mem_stage #(.DM_LATENCY(LB)) dut_b (.clk(clk), .rst(rst), .mem(if1.slave));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? LA : LB;
    endfunction

    // Reference load alignment: shift the addressed byte down, optionally sign-extend
    function automatic logic [31:0] ref_align(input logic [31:0] rd, input int a,
                                              input logic wd, input logic sg);
        logic [31:0] b;
        if (wd) return rd;
        b = (rd >> (8 * a)) & 32'hFF;
        if (sg && b >= 32'd128) b = b - 32'd256;
        return b;
    endfunction

    function automatic logic [153:0] mk(input logic [3:0] ctl, input logic [31:0] sd,
                                        input logic [31:0] res, input logic [4:0] wd,
                                        input logic [31:0] pc);
        return {ctl, sd, res, ~res, pc[15:0], 1'b1, wd, pc};
    endfunction

    // Model: how many consecutive cycles the current load has been live, and the value it captured
    int          age [N] = '{0, 0};
    logic [31:0] cap [N] = '{32'h0, 32'h0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                age[i] <= 0;
                cap[i] <= 32'h0;
            end else if (!valid_r[i] || !bus_r[i][153]) begin
                age[i] <= 0;
            end else if (age[i] > lat(i)) begin
                if (adv_r[i]) age[i] <= 0;
            end else begin
                if (age[i] == lat(i))
                    cap[i] <= ref_align(rdata_r[i], int'(bus_r[i][87:86]), bus_r[i][151], bus_r[i][150]);
                age[i] <= age[i] + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [153:0] b;
        logic         ld, st, wd, mis, eo;
        int           a;
        logic [31:0]  res, sd;
        logic [3:0]   ew;
        logic [117:0] eb;
        string        tag;
        for (int i = 0; i < N; i++) begin
            b   = bus_r[i];
            ld  = b[153];
            st  = b[152];
            wd  = b[151];
            sd  = b[149:118];
            res = b[117:86];
            a   = int'(res[1:0]);
            tag = (i == 0) ? "L1" : "L3";
            mis = CHK && wd && (ld || st) && (a != 0);
            eo  = valid_r[i] && (!ld || age[i] > lat(i));
            ew  = 4'h0;
            if (valid_r[i] && st && !mis) ew = wd ? 4'hF : 4'(1 << a);
            chk({tag, " over"},  128'(over_o[i]),  128'(eo));
            chk({tag, " wen"},   128'(wen_o[i]),   128'(ew));
            chk({tag, " addr"},  128'(addr_o[i]),  128'(res));
            chk({tag, " wdata"}, 128'(wdata_o[i]), 128'(wd ? sd : sd[7:0] * 32'h01010101));
            chk({tag, " wdest"}, 128'(wdest_o[i]), 128'(valid_r[i] ? b[36:32] : 5'd0));
            chk({tag, " exc"},   128'(exc_o[i]),   128'(valid_r[i] && mis));
            chk({tag, " pc"},    128'(pc_o[i]),    128'(b[31:0]));
            if (eo) begin
                eb = {b[37] & !(ld && mis), b[36:32], ld ? cap[i] : res, b[85:54], b[53:38], b[31:0]};
                chk({tag, " wb_bus"}, 128'(wb_o[i]), 128'(eb));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one load, stall WB for 'stall' cycles once it completes, then advance
    task automatic do_load(input int i, input logic [3:0] ctl, input logic [31:0] addr,
                           input logic [31:0] value, input int stall,
                           input logic [31:0] exp, input logic exp_rfw);
        int l;
        l = lat(i);
        bus_r[i]   = mk(ctl, 32'h0, addr, 5'd9, 32'h0040_1000 + addr);
        valid_r[i] = 1'b1;
        adv_r[i]   = 1'b0;
        rdata_r[i] = 32'h5A5A5A5A;
        #2 chk("load early over c0", 128'(over_o[i]), 128'(0));
        for (int c = 1; c <= l; c++) begin
            step();
            rdata_r[i] = (c == l) ? value : 32'hA5A5A5A5;
            #2 chk("load early over", 128'(over_o[i]), 128'(0));
        end
        step();
        rdata_r[i] = ~value;
        for (int s = 0; s < stall; s++) begin
            #2;
            chk("stall over", 128'(over_o[i]), 128'(1));
            chk("stall result", 128'(wb_o[i][111:80]), 128'(exp));
            step();
            rdata_r[i] = value ^ (32'h1111_0000 + 32'(s));
        end
        adv_r[i] = 1'b1;
        #2;
        chk("load over", 128'(over_o[i]), 128'(1));
        chk("load result", 128'(wb_o[i][111:80]), 128'(exp));
        chk("load model cap", 128'(cap[i]), 128'(exp));
        chk("load rf_wen", 128'(wb_o[i][117]), 128'(exp_rfw));
        step();
        adv_r[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            valid_r[i] = 1'b0;
            adv_r[i]   = 1'b0;
            bus_r[i]   = mk(C_LW, 32'h0, 32'h0000_0100, 5'd3, 32'h0040_0000);
            rdata_r[i] = 32'h0;
        end
        step();
        step();
        chk("reset over", 128'(over_o[0]), 128'(0));
        chk("reset wen", 128'(wen_o[1]), 128'(0));
        chk("reset load_data", 128'(wb_o[0][111:80]), 128'(0));
        rst = 1'b0;
        step();

        // ALU pass-through
        bus_r[0] = mk(C_ALU, 32'h0, 32'h12345678, 5'd5, 32'h0040_0400);
        valid_r[0] = 1'b1;
        adv_r[0]   = 1'b1;
        #2;
        chk("alu over", 128'(over_o[0]), 128'(1));
        chk("alu result", 128'(wb_o[0][111:80]), 128'(32'h12345678));
        chk("alu wdest", 128'(wdest_o[0]), 128'(5));
        step();

        // SB / SW
        bus_r[0] = mk(C_SB, 32'h0000_00AB, 32'h0000_0103, 5'd0, 32'h0040_0404);
        #2;
        chk("sb wen", 128'(wen_o[0]), 128'(4'b1000));
        chk("sb wdata", 128'(wdata_o[0]), 128'(32'hABABABAB));
        step();
        bus_r[0] = mk(C_SW, 32'hDEADBEEF, 32'h0000_0100, 5'd0, 32'h0040_0408);
        #2;
        chk("sw wen", 128'(wen_o[0]), 128'(4'b1111));
        chk("sw wdata", 128'(wdata_o[0]), 128'(32'hDEADBEEF));
        step();

        // Back-to-back loads, latency 1
        do_load(0, C_LB,  32'h0000_0203, 32'h80FF7F01, 0, 32'hFFFFFF80, 1'b1);
        do_load(0, C_LBU, 32'h0000_0203, 32'h80FF7F01, 0, 32'h00000080, 1'b1);
        do_load(0, C_LW,  32'h0000_0200, 32'h80FF7F01, 0, 32'h80FF7F01, 1'b1);
        do_load(0, C_LB,  32'h0000_0201, 32'h80FF7F01, 1, 32'h0000007F, 1'b1);
        do_load(0, C_LB,  32'h0000_0202, 32'h80FF7F01, 0, 32'hFFFFFFFF, 1'b1);
        do_load(0, C_LBU, 32'h0000_0200, 32'h80FF7F01, 0, 32'h00000001, 1'b1);

        // Invalid instruction: no over, no hazard dest
        bus_r[0]   = mk(C_ALU, 32'h0, 32'h0000_0010, 5'd7, 32'h0040_0500);
        valid_r[0] = 1'b0;
        #2 chk("invalid wdest", 128'(wdest_o[0]), 128'(0));

        // Latency 3 with a 4-cycle WB stall and changing RAM data
        do_load(1, C_LW, 32'h0000_0300, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b1);
        do_load(1, C_LB, 32'h0000_0300, 32'h80FF7F01, 0, 32'h00000001, 1'b1);

        // Flush during WAIT, then a normal load
        bus_r[1] = mk(C_LW, 32'h0, 32'h0000_0310, 5'd4, 32'h0040_0600);
        rdata_r[1] = 32'h0;
        step();
        valid_r[1] = 1'b0;
        #2 chk("flush over", 128'(over_o[1]), 128'(0));
        step();
        do_load(1, C_LW, 32'h0000_0314, 32'h13572468, 0, 32'h13572468, 1'b1);
        valid_r[1] = 1'b0;
        step();

        // Reset pulse while a load waits for data
        bus_r[0]   = mk(C_LW, 32'h0, 32'h0000_0400, 5'd6, 32'h0040_0700);
        valid_r[0] = 1'b1;
        adv_r[0]   = 1'b0;
        rdata_r[0] = 32'h0;
        step();
        rdata_r[0] = 32'h7777_8888;
        #1 rst = 1'b1;
        valid_r[0] = 1'b0;
        #1 rst = 1'b0;
        #1 chk("rst pulse over", 128'(over_o[0]), 128'(0));
        step();
        #2 chk("after rst over", 128'(over_o[0]), 128'(0));
        step();
        do_load(0, C_LW, 32'h0000_0404, 32'h2468ACE0, 0, 32'h2468ACE0, 1'b1);

        // Misaligned word accesses
        bus_r[0]   = mk(C_SW, 32'h11223344, 32'h0000_0102, 5'd0, 32'h0040_0800);
        valid_r[0] = 1'b1;
        adv_r[0]   = 1'b1;
        #2;
        chk("misaligned sw wen", 128'(wen_o[0]), 128'(CHK ? 4'h0 : 4'hF));
        chk("misaligned sw exc", 128'(exc_o[0]), 128'(CHK));
        step();
        do_load(0, C_LW, 32'h0000_0101, 32'h55667788, 0, 32'h55667788, !CHK);

        valid_r[0] = 1'b0;
        adv_r[0]   = 1'b0;
        valid_r[1] = 1'b0;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
